pcie_flr_bfm: RTL and testbench
===============================

# pcie_flr_bfm

Root-port-side Function Level Reset (FLR) model for the PCIe simulation bench. It accepts FLR requests from the test sequencer for a PF or a VF and drives the FLR sideband into the FIM's FLR handling logic. It tracks which PFs and VFs are in reset and clears each one when the FIM reports completion. It sits between the tester and the DUT's PCIe sideband.

## Interface
- MAX_NUM_VF, default 2048: number of VF slots tracked per PF; legal range 1..2048.
- clk  in  1  bench clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_assert_flr  in  1  one-cycle FLR request strobe.
- i_vf_active  in  1  request qualifier: 1 = VF FLR, 0 = PF FLR.
- i_pf_num  in  3  target PF.
- i_vf_num  in  11  target VF; ignored for PF FLR.
- i_flr_pf_done  in  8  per-PF completion indication from the FIM.
- o_flr_pf_active  out  8  per-PF FLR-in-progress flags; level signals.
- o_flr_rcvd_vf  out  1  one-cycle VF FLR notification to the FIM.
- o_flr_rcvd_pf_num  out  3  PF of the notified VF.
- o_flr_rcvd_vf_num  out  11  VF of the notified VF.
- o_flr_vf_active  out  [7:0][MAX_NUM_VF-1:0]  per-PF, per-VF FLR-in-progress flags.
- i_flr_completed_vf  in  1  one-cycle VF FLR completion strobe from the FIM.
- i_flr_completed_pf_num  in  3  PF of the completed VF.
- i_flr_completed_vf_num  in  11  VF of the completed VF.

## Operation
- Reset values: all outputs are 0, including all o_flr_vf_active bits and the rcvd PF/VF numbers.
- PF FLR (i_assert_flr=1, i_vf_active=0):
  - Sets o_flr_pf_active[i_pf_num].
  - The bit clears the cycle after i_flr_pf_done[p]=1 is sampled while the bit is set.
  - i_flr_pf_done for a PF that is not active is ignored.
- VF FLR (i_assert_flr=1, i_vf_active=1, i_vf_num < MAX_NUM_VF, slot not already active):
  - Sets o_flr_vf_active[pf][vf].
  - Pulses o_flr_rcvd_vf for exactly one cycle with the registered PF/VF numbers.
- VF completion: i_flr_completed_vf=1 clears o_flr_vf_active[completed_pf][completed_vf]. Completion for an inactive slot is a no-op.
- Re-assert of an already-active PF or VF is a no-op; no second rcvd pulse is produced.
- VF number ≥ MAX_NUM_VF: the request is dropped with no output change.
- Simultaneous set and clear of the same PF bit or VF slot in one cycle: set wins, and the bit remains 1.
- Set and clear of different slots in the same cycle are both applied.
- Only one request per cycle is accepted, since there is a single strobe; there is no queueing.
- rst_n asserted mid-FLR immediately clears all state. Outstanding completions arriving after reset are ignored.

## Timing
- Request strobe at edge N → o_flr_pf_active / o_flr_vf_active / o_flr_rcvd_vf valid after edge N+1 (1-cycle latency).
- o_flr_rcvd_vf is high for exactly one cycle. o_flr_rcvd_pf_num/vf_num hold their last value after the pulse.
- Done/completion sampled at edge M → flag low after edge M+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- PCIE_FLR_VF_EN defined: full PF and VF behaviour as above.
- PCIE_FLR_VF_EN undefined:
  - The VF path is compiled out.
  - o_flr_rcvd_vf, o_flr_rcvd_pf_num, o_flr_rcvd_vf_num and o_flr_vf_active are tied to 0.
  - VF requests and i_flr_completed_* are ignored.
  - The PF path is unchanged.

## Structure
- Shared package pcie_flr_pkg: NUM_PF=8, PF_NUM_W=3, VF_NUM_W=11, MAX_NUM_VF_LIMIT=2048, and a request struct {vf_active, pf_num, vf_num}.
- One sub-module, pcie_flr_vf_tracker: the per-PF VF bit array with set/clear/priority logic. It is instantiated 8 times and only under PCIE_FLR_VF_EN.
- The PF flags and the rcvd pulse register live in the top level.

## Test plan
- PF FLR on PF 2, then i_flr_pf_done[2] three cycles later → o_flr_pf_active=8'h04 one cycle after the strobe, back to 8'h00 one cycle after done.
- VF FLR on PF 0 / VF 5 → o_flr_rcvd_vf pulses once with pf=0, vf=5 and o_flr_vf_active[0][5]=1. Completion (0,5) clears it; (0,6) is set and completed independently.
- Re-assert VF (1,3) while active → no second rcvd pulse. Completion of the inactive slot (1,4) → no change.
- Same-cycle set (3,7) and completion (3,7) → slot remains 1. Same-cycle PF 4 assert and i_flr_pf_done[4] → bit remains 1.
- VF request with vf_num=MAX_NUM_VF (MAX_NUM_VF=16 build) → dropped, no pulse. With rst_n low mid-FLR, all outputs are 0 immediately.
- Build without PCIE_FLR_VF_EN: VF request (0,1) → no pulse and vf_active all 0. A PF FLR on PF 1 still works.

Source files
------------

// File: rtl/pcie_flr_pkg.sv
// Shared FLR definitions: PF/VF widths, VF slot limit and the request record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pcie_flr_pkg;

  localparam int NUM_PF           = 8;
  localparam int PF_NUM_W         = 3;
  localparam int VF_NUM_W         = 11;
  localparam int MAX_NUM_VF_LIMIT = 2048;

  typedef struct packed {
    logic                vf_active;
    logic [PF_NUM_W-1:0] pf_num;
    logic [VF_NUM_W-1:0] vf_num;
  } flr_req_t;

  // One-hot PF select used to set a single PF flag
  function automatic logic [NUM_PF-1:0] pf_onehot(input logic [PF_NUM_W-1:0] pf);
    pf_onehot     = '0;
    pf_onehot[pf] = 1'b1;
  endfunction

endpackage

// File: rtl/pcie_flr_vf_tracker.sv
// Per-PF VF FLR-in-progress bit array with set/clear; set beats clear on the same slot.
// Latency: set/clear visible one cycle after the strobe; set_new is combinational from current state.
// Backpressure: none; VF numbers outside the slot range match nothing and are dropped.
module pcie_flr_vf_tracker
  import pcie_flr_pkg::*;
#(
  parameter int MAX_NUM_VF = MAX_NUM_VF_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_vld,
  input  logic [VF_NUM_W-1:0]   set_vf,
  input  logic                  clr_vld,
  input  logic [VF_NUM_W-1:0]   clr_vf,
  output logic                  set_new,
  output logic [MAX_NUM_VF-1:0] vf_active
);

  logic [MAX_NUM_VF-1:0] set_mask;
  logic [MAX_NUM_VF-1:0] clr_mask;

  // Decode set/clear targets into slot masks; an out-of-range number yields an empty mask
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < MAX_NUM_VF; i++) begin
      set_mask[i] = set_vld && (set_vf == VF_NUM_W'(i));
      clr_mask[i] = clr_vld && (clr_vf == VF_NUM_W'(i));
    end
  end

  // A request only counts as new when it lands on a slot that is currently idle
  assign set_new = |(set_mask & ~vf_active);

  // Apply completion first, then the request, so a same-cycle set leaves the slot active
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vf_active <= '0;
    end else begin
      vf_active <= (vf_active & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: rtl/pcie_flr_bfm.sv
// Root-port FLR model: tracks PF/VF resets requested by the sequencer until the FIM completes them.
// Latency: 1 cycle from request/done/completion to flags and rcvd pulse; all outputs registered.
// Backpressure: none; one request per cycle, re-asserts and out-of-range VFs are dropped. VF path needs PCIE_FLR_VF_EN.
module pcie_flr_bfm
  import pcie_flr_pkg::*;
#(
  parameter int MAX_NUM_VF = 2048
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_assert_flr,
  input  logic                               i_vf_active,
  input  logic [PF_NUM_W-1:0]                i_pf_num,
  input  logic [VF_NUM_W-1:0]                i_vf_num,
  input  logic [NUM_PF-1:0]                  i_flr_pf_done,
  output logic [NUM_PF-1:0]                  o_flr_pf_active,
  output logic                               o_flr_rcvd_vf,
  output logic [PF_NUM_W-1:0]                o_flr_rcvd_pf_num,
  output logic [VF_NUM_W-1:0]                o_flr_rcvd_vf_num,
  output logic [NUM_PF-1:0][MAX_NUM_VF-1:0]  o_flr_vf_active,
  input  logic                               i_flr_completed_vf,
  input  logic [PF_NUM_W-1:0]                i_flr_completed_pf_num,
  input  logic [VF_NUM_W-1:0]                i_flr_completed_vf_num
);

  flr_req_t req;
  logic     pf_req;

  assign req    = '{vf_active: i_vf_active, pf_num: i_pf_num, vf_num: i_vf_num};
  assign pf_req = i_assert_flr && !req.vf_active;

  // PF flags: done clears only set bits, a new request sets its bit and wins over done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_flr_pf_active <= '0;
    end else begin
      o_flr_pf_active <= (o_flr_pf_active & ~i_flr_pf_done)
                       | (pf_req ? pf_onehot(req.pf_num) : '0);
    end
  end

`ifdef PCIE_FLR_VF_EN
  logic              vf_req;
  logic [NUM_PF-1:0] set_new;

  assign vf_req = i_assert_flr && req.vf_active;

  for (genvar p = 0; p < NUM_PF; p++) begin : g_vf
    pcie_flr_vf_tracker #(
      .MAX_NUM_VF(MAX_NUM_VF)
    ) u_trk (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_vld  (vf_req && (req.pf_num == PF_NUM_W'(p))),
      .set_vf   (req.vf_num),
      .clr_vld  (i_flr_completed_vf && (i_flr_completed_pf_num == PF_NUM_W'(p))),
      .clr_vf   (i_flr_completed_vf_num),
      .set_new  (set_new[p]),
      .vf_active(o_flr_vf_active[p])
    );
  end

  // Notify the FIM once per newly accepted VF FLR; the numbers hold after the pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_flr_rcvd_vf     <= 1'b0;
      o_flr_rcvd_pf_num <= '0;
      o_flr_rcvd_vf_num <= '0;
    end else begin
      o_flr_rcvd_vf <= |set_new;
      if (|set_new) begin
        o_flr_rcvd_pf_num <= req.pf_num;
        o_flr_rcvd_vf_num <= req.vf_num;
      end
    end
  end
`else
  logic unused_vf_path;

  assign o_flr_rcvd_vf     = 1'b0;
  assign o_flr_rcvd_pf_num = '0;
  assign o_flr_rcvd_vf_num = '0;
  assign o_flr_vf_active   = '0;
  assign unused_vf_path    = ^{req.vf_num, i_flr_completed_vf,
                               i_flr_completed_pf_num, i_flr_completed_vf_num};
`endif

endmodule

// File: tb/tb_pcie_flr_bfm.sv
// Bench for pcie_flr_bfm: directed scenarios then random traffic against a slot-level model.
// Latency: expects every effect one clock after the sampling edge.
// Backpressure: n/a; model follows the PCIE_FLR_VF_EN build of the DUT.
module tb_pcie_flr_bfm;

  localparam int MAX_VF = 16;
`ifdef PCIE_FLR_VF_EN
  localparam bit VF_EN = 1'b1;
`else
  localparam bit VF_EN = 1'b0;
`endif

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          i_assert_flr;
  logic                          i_vf_active;
  logic [2:0]                    i_pf_num;
  logic [10:0]                   i_vf_num;
  logic [7:0]                    i_flr_pf_done;
  logic [7:0]                    o_flr_pf_active;
  logic                          o_flr_rcvd_vf;
  logic [2:0]                    o_flr_rcvd_pf_num;
  logic [10:0]                   o_flr_rcvd_vf_num;
  logic [7:0][MAX_VF-1:0]        o_flr_vf_active;
  logic                          i_flr_completed_vf;
  logic [2:0]                    i_flr_completed_pf_num;
  logic [10:0]                   i_flr_completed_vf_num;

  int checks = 0;
  int errors = 0;

  // Reference state: which PFs and VF slots are in reset, and the last notification
  bit [7:0] m_pf;
  bit       m_vf [8][MAX_VF];
  bit       m_rcvd;
  bit [2:0] m_rpf;
  bit [10:0] m_rvf;

  pcie_flr_bfm #(.MAX_NUM_VF(MAX_VF)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_assert_flr          (i_assert_flr),
    .i_vf_active           (i_vf_active),
    .i_pf_num              (i_pf_num),
    .i_vf_num              (i_vf_num),
    .i_flr_pf_done         (i_flr_pf_done),
    .o_flr_pf_active       (o_flr_pf_active),
    .o_flr_rcvd_vf         (o_flr_rcvd_vf),
    .o_flr_rcvd_pf_num     (o_flr_rcvd_pf_num),
    .o_flr_rcvd_vf_num     (o_flr_rcvd_vf_num),
    .o_flr_vf_active       (o_flr_vf_active),
    .i_flr_completed_vf    (i_flr_completed_vf),
    .i_flr_completed_pf_num(i_flr_completed_pf_num),
    .i_flr_completed_vf_num(i_flr_completed_vf_num)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pf = '0; m_rcvd = 1'b0; m_rpf = '0; m_rvf = '0;
    for (int p = 0; p < 8; p++)
      for (int v = 0; v < MAX_VF; v++) m_vf[p][v] = 1'b0;
  endtask

  // Apply the rules for one sampling edge using the inputs currently driven
  task automatic model_edge();
    bit [7:0] npf;
    bit       ok;
    bit       was;
    npf = m_pf & ~i_flr_pf_done;
    if (i_assert_flr && !i_vf_active) npf[i_pf_num] = 1'b1;
    m_rcvd = 1'b0;
    if (VF_EN) begin
      ok  = i_assert_flr && i_vf_active && (i_vf_num < MAX_VF);
      was = ok ? m_vf[i_pf_num][i_vf_num[3:0]] : 1'b0;
      if (i_flr_completed_vf && i_flr_completed_vf_num < MAX_VF)
        m_vf[i_flr_completed_pf_num][i_flr_completed_vf_num[3:0]] = 1'b0;
      if (ok) begin
        m_vf[i_pf_num][i_vf_num[3:0]] = 1'b1;
        if (!was) begin
          m_rcvd = 1'b1;
          m_rpf  = i_pf_num;
          m_rvf  = i_vf_num;
        end
      end
    end
    m_pf = npf;
  endtask

  task automatic check_all(input string tag);
    logic [7:0][MAX_VF-1:0] ev;
    for (int p = 0; p < 8; p++)
      for (int v = 0; v < MAX_VF; v++) ev[p][v] = m_vf[p][v];
    chk({tag, ".pf_active"}, 128'(o_flr_pf_active), 128'(m_pf));
    chk({tag, ".rcvd_vf"},   128'(o_flr_rcvd_vf),   128'(m_rcvd));
    chk({tag, ".rcvd_pf"},   128'(o_flr_rcvd_pf_num), 128'(m_rpf));
    chk({tag, ".rcvd_vfn"},  128'(o_flr_rcvd_vf_num), 128'(m_rvf));
    chk({tag, ".vf_active"}, 128'(o_flr_vf_active), 128'(ev));
  endtask

  // Drive one cycle of stimulus, let the edge sample it, then compare against the model
  task automatic cyc(input string tag, input bit a, input bit va, input int pf, input int vf,
                     input bit [7:0] done, input bit cv, input int cpf, input int cvf);
    i_assert_flr           = a;
    i_vf_active            = va;
    i_pf_num               = 3'(pf);
    i_vf_num               = 11'(vf);
    i_flr_pf_done          = done;
    i_flr_completed_vf     = cv;
    i_flr_completed_pf_num = 3'(cpf);
    i_flr_completed_vf_num = 11'(cvf);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_assert_flr = 0; i_vf_active = 0; i_pf_num = 0; i_vf_num = 0;
    i_flr_pf_done = 0; i_flr_completed_vf = 0;
    i_flr_completed_pf_num = 0; i_flr_completed_vf_num = 0;
    model_reset();
    #23;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // PF 2 FLR, done three cycles after the strobe
    cyc("pf2_set", 1, 0, 2, 0, 8'h00, 0, 0, 0);
    chk("pf2_set_const", 128'(o_flr_pf_active), 128'h04);
    idle("pf2_wait1");
    idle("pf2_wait2");
    cyc("pf2_done", 0, 0, 0, 0, 8'h04, 0, 0, 0);
    chk("pf2_done_const", 128'(o_flr_pf_active), 128'h00);
    cyc("pf5_done_idle", 0, 0, 0, 0, 8'h20, 0, 0, 0);

    // VF (0,5) notification and completion, (0,6) independent
    cyc("vf05_set", 1, 1, 0, 5, 8'h00, 0, 0, 0);
    chk("vf05_pulse", 128'(o_flr_rcvd_vf), 128'(VF_EN));
    idle("vf05_pulse_end");
    chk("vf05_one_pulse", 128'(o_flr_rcvd_vf), 128'h0);
    cyc("vf06_set", 1, 1, 0, 6, 8'h00, 0, 0, 0);
    cyc("vf05_clr", 0, 0, 0, 0, 8'h00, 1, 0, 5);
    cyc("vf06_clr", 0, 0, 0, 0, 8'h00, 1, 0, 6);

    // Re-assert of an active slot, completion of an idle slot
    cyc("vf13_set", 1, 1, 1, 3, 8'h00, 0, 0, 0);
    idle("vf13_idle");
    cyc("vf13_reassert", 1, 1, 1, 3, 8'h00, 0, 0, 0);
    chk("vf13_no_pulse", 128'(o_flr_rcvd_vf), 128'h0);
    cyc("vf14_clr_idle", 0, 0, 0, 0, 8'h00, 1, 1, 4);

    // Same-cycle set and clear on one slot / one PF
    cyc("vf37_set_clr", 1, 1, 3, 7, 8'h00, 1, 3, 7);
    cyc("pf4_set_done", 1, 0, 4, 0, 8'h10, 0, 0, 0);
    chk("pf4_set_wins", 128'(o_flr_pf_active[4]), 128'h1);
    cyc("vf21_set_clr37", 1, 1, 2, 1, 8'h00, 1, 3, 7);

    // Out-of-range VF is dropped
    cyc("vf_oor", 1, 1, 2, MAX_VF, 8'h00, 0, 0, 0);
    chk("vf_oor_no_pulse", 128'(o_flr_rcvd_vf), 128'h0);

    // Asynchronous reset mid-FLR clears everything immediately
    cyc("pf6_set", 1, 0, 6, 0, 8'h00, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst_pf", 128'(o_flr_pf_active), 128'h0);
    #1 rst_n = 1'b1;
    cyc("stale_done", 0, 0, 0, 0, 8'h40, 1, 1, 3);

    // VF request (0,1) then PF 1
    cyc("vf01_req", 1, 1, 0, 1, 8'h00, 0, 0, 0);
    cyc("pf1_set", 1, 0, 1, 0, 8'h00, 0, 0, 0);
    chk("pf1_set_const", 128'(o_flr_pf_active[1]), 128'h1);
    cyc("pf1_done", 0, 0, 0, 0, 8'h02, 0, 0, 0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      bit [7:0] done;
      done = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cyc("rand", ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
          $urandom_range(0, 7), $urandom_range(0, MAX_VF + 1), done,
          ($urandom_range(0, 2) == 0), $urandom_range(0, 7), $urandom_range(0, MAX_VF - 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
